// File: rtl/alu_issue_stage_if.sv
// Command and result handshake bundle for alu_issue_stage.
// The stage is the slave of this bundle; the surrounding environment is the master.
interface alu_issue_stage_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [3:0] cmd_op;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_zero;
  logic       res_dz;
  logic       res_ill;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, res_ready,
    output cmd_ready, res_valid, res_data, res_zero, res_dz, res_ill
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, res_ready,
    input  cmd_ready, res_valid, res_data, res_zero, res_dz, res_ill
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Issue stage around a 4-bit combinational ALU: 2-entry command FIFO, registered
// operands, policed result capture and a valid/ready result register.
module alu_issue_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_issue_stage_if.slave bus,
  output logic [3:0]       alu_a_o,
  output logic [3:0]       alu_b_o,
  output logic [3:0]       alu_op_o,
  input  logic [7:0]       alu_r_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] op_count_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  localparam logic [3:0] OP_DIV = 4'b0111;

  state_t           state_q, state_d;
  logic [11:0]      fifo_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q, count_d;
  logic             ready_q;
  logic [3:0]       a_q, b_q, op_q;
  logic [7:0]       res_q, res_d;
  logic             zero_q, dz_q, ill_q;
  logic             dz_d, ill_d, legal;
  logic [CNT_W-1:0] cnt_q;
  logic             push, pop, capture, handshake;

  // ready_q keeps cmd_ready low until the first edge after reset release
  assign bus.cmd_ready = ready_q && (count_q != 2'd2);
  assign push          = bus.cmd_valid && bus.cmd_ready;
  assign handshake     = (state_q == HOLD) && bus.res_ready;
  assign count_d       = count_q + {1'b0, push} - {1'b0, pop};

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != 2'd0) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        capture = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (bus.res_ready) begin
          if (count_q != 2'd0) begin
            pop     = 1'b1;
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    legal = 1'b1;
    case (op_q)
      4'b0010, 4'b0100, 4'b0101, 4'b0110, 4'b1110: legal = 1'b0;
      default: legal = 1'b1;
    endcase
  end

  // Illegal opcodes win over divide-by-zero; both override the ALU result
  always_comb begin
    ill_d = !legal;
    dz_d  = legal && (op_q == OP_DIV) && (b_q == 4'h0);
    res_d = alu_r_i;
    if (ill_d) begin
      res_d = 8'h00;
    end else if (dz_d) begin
      res_d = 8'hFF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      ready_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      res_q     <= '0;
      zero_q    <= 1'b0;
      dz_q      <= 1'b0;
      ill_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ready_q <= 1'b1;
      if (push) begin
        fifo_q[wr_ptr_q] <= {bus.cmd_op, bus.cmd_a, bus.cmd_b};
        wr_ptr_q         <= !wr_ptr_q;
      end
      if (pop) begin
        {op_q, a_q, b_q} <= fifo_q[rd_ptr_q];
        rd_ptr_q         <= !rd_ptr_q;
      end
      if (capture) begin
        res_q  <= res_d;
        zero_q <= (res_d == 8'h00);
        dz_q   <= dz_d;
        ill_q  <= ill_d;
      end
      if (handshake) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign alu_a_o       = a_q;
  assign alu_b_o       = b_q;
  assign alu_op_o      = op_q;
  assign bus.res_valid = (state_q == HOLD);
  assign bus.res_data  = res_q;
  assign bus.res_zero  = zero_q;
  assign bus.res_dz    = dz_q;
  assign bus.res_ill   = ill_q;
  assign busy_o        = (count_q != 2'd0) || (state_q != IDLE);
  assign op_count_o    = cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: a behavioural ALU feeds alu_r, and
// expected {data, zero, dz, ill} results are queued on acceptance and popped on output.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rstN;
  logic [3:0]  aluA, aluB, aluOp;
  logic [7:0]  aluR;
  logic        busy;
  logic [3:0]  opCount;
  logic [10:0] expQ [$];
  int          checks = 0;
  int          passes = 0;

  alu_issue_stage_if bus();

  alu_issue_stage #(.CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rstN),
    .bus        (bus),
    .alu_a_o    (aluA),
    .alu_b_o    (aluB),
    .alu_op_o   (aluOp),
    .alu_r_i    (aluR),
    .busy_o     (busy),
    .op_count_o (opCount)
  );

  always #5 clk = ~clk;

  // External ALU: divide-by-zero and illegal codes return junk the stage must not pass on
  function automatic logic [7:0] aluModel(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
    logic [7:0] xa, xb;
    xa = {4'h0, a};
    xb = {4'h0, b};
    case (op)
      4'h0:    return xa + xb;
      4'h1:    return xa - xb;
      4'h3:    return xa * xb;
      4'h7:    return (b == 4'h0) ? 8'h5A : xa / xb;
      4'hF:    return xa & xb;
      4'h8:    return xa | xb;
      4'h9:    return ~xa;
      4'hB:    return ~(xa & xb);
      4'hA:    return ~(xa | xb);
      4'hC:    return xa ^ xb;
      4'hD:    return ~(xa ^ xb);
      default: return 8'hC3;
    endcase
  endfunction

  assign aluR = aluModel(aluA, aluB, aluOp);

  // Holds a command until accepted, queuing its expected result at acceptance
  task automatic sendCmd(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op, input logic [10:0] expRes);
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_op    = op;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (bus.cmd_ready) begin
        expQ.push_back(expRes);
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        return;
      end
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    $display("[TB] FAIL send_timeout: cmd_ready=%b required 1 within 50 cycles", bus.cmd_ready);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic waitResult(output bit seen, output int cycles);
    cycles = 0;
    while (!bus.res_valid && cycles < 30) begin
      @(posedge clk);
      @(negedge clk);
      cycles++;
    end
    seen = bus.res_valid;
  endtask

  task automatic takeResult();
    bus.res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  task automatic doReset();
    rstN          = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b0;
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    @(negedge clk);
    expQ.delete();
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.cmd_ready, bus.res_valid, bus.res_data, bus.res_zero, bus.res_dz, bus.res_ill,
         busy, opCount, aluA, aluB, aluOp} !== 30'h0)
      $display("[TB] FAIL reset_outputs: got ready=%b valid=%b data=%h busy=%b cnt=%h required all 0",
               bus.cmd_ready, bus.res_valid, bus.res_data, busy, opCount);
    else passes++;
    rstN = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b required 1", bus.cmd_ready);
    else passes++;
    checks++;
    if ({busy, bus.res_valid} !== 2'b00) $display("[TB] FAIL reset_idle: got busy/valid %b required 00", {busy, bus.res_valid});
    else passes++;
  endtask

  task automatic test_latency();
    logic [10:0] expRes;
    bus.res_ready = 1'b0;
    sendCmd(4'hF, 4'hF, 4'h0, {8'h1E, 3'b000});
    checks++;
    if ({bus.res_valid, busy} !== 2'b01) $display("[TB] FAIL lat_e0: got valid/busy %b required 01", {bus.res_valid, busy});
    else passes++;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.res_valid, aluOp, aluA, aluB} !== {1'b0, 4'h0, 4'hF, 4'hF})
      $display("[TB] FAIL lat_e1: got valid=%b op=%h a=%h b=%h required 0 0 f f", bus.res_valid, aluOp, aluA, aluB);
    else passes++;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (!bus.res_valid || expQ.size() == 0) $display("[TB] FAIL lat_e2: res_valid=%b required 1 two cycles after accept", bus.res_valid);
    else begin
      expRes = expQ.pop_front();
      if ({bus.res_data, bus.res_zero, bus.res_dz, bus.res_ill} !== expRes)
        $display("[TB] FAIL lat_result: got %h required %h", {bus.res_data, bus.res_zero, bus.res_dz, bus.res_ill}, expRes);
      else passes++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.res_valid, bus.res_data} !== {1'b1, 8'h1E}) $display("[TB] FAIL lat_hold: got valid=%b data=%h required 1 1e", bus.res_valid, bus.res_data);
    else passes++;
    takeResult();
    checks++;
    if ({opCount, bus.res_valid, busy} !== {4'd1, 2'b00}) $display("[TB] FAIL lat_count: got cnt=%h valid=%b busy=%b required 1 0 0", opCount, bus.res_valid, busy);
    else passes++;
  endtask

  task automatic test_div();
    logic [10:0] expRes;
    bit          seen;
    int          cyc;
    bus.res_ready = 1'b0;
    sendCmd(4'h9, 4'h0, 4'h7, {8'hFF, 3'b010});
    sendCmd(4'h9, 4'h2, 4'h7, {8'h04, 3'b000});
    for (int k = 0; k < 2; k++) begin
      waitResult(seen, cyc);
      checks++;
      if (!seen || expQ.size() == 0) $display("[TB] FAIL div_result%0d: got no result required one", k);
      else begin
        expRes = expQ.pop_front();
        if ({bus.res_data, bus.res_zero, bus.res_dz, bus.res_ill} !== expRes)
          $display("[TB] FAIL div_result%0d: got %h required %h", k, {bus.res_data, bus.res_zero, bus.res_dz, bus.res_ill}, expRes);
        else passes++;
      end
      takeResult();
    end
  endtask

  task automatic test_illegal();
    logic [10:0] expRes;
    bit          seen;
    int          cyc;
    bus.res_ready = 1'b0;
    sendCmd(4'h3, 4'h4, 4'h5, {8'h00, 3'b101});
    sendCmd(4'hA, 4'h5, 4'hF, {8'h00, 3'b100});
    for (int k = 0; k < 2; k++) begin
      waitResult(seen, cyc);
      checks++;
      if (!seen || expQ.size() == 0) $display("[TB] FAIL ill_result%0d: got no result required one", k);
      else begin
        expRes = expQ.pop_front();
        if ({bus.res_data, bus.res_zero, bus.res_dz, bus.res_ill} !== expRes)
          $display("[TB] FAIL ill_result%0d: got %h required %h", k, {bus.res_data, bus.res_zero, bus.res_dz, bus.res_ill}, expRes);
        else passes++;
      end
      takeResult();
    end
  endtask

  // Every opcode with a=6 b=3; illegal codes must come back as 00 with ill set
  task automatic test_opcodes();
    logic [7:0]  dataTab [16];
    logic [15:0] illMask;
    logic [10:0] expRes;
    bit          seen;
    int          cyc;
    dataTab = '{8'h09, 8'h03, 8'h00, 8'h12, 8'h00, 8'h00, 8'h00, 8'h02,
                8'h07, 8'hF9, 8'hF8, 8'hFD, 8'h05, 8'hFA, 8'h00, 8'h02};
    illMask = 16'h4074;
    bus.res_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      sendCmd(4'h6, 4'h3, 4'(i), {dataTab[i], illMask[i], 1'b0, illMask[i]});
      waitResult(seen, cyc);
      checks++;
      if (!seen || expQ.size() == 0) $display("[TB] FAIL op%0h_result: got no result required one", i);
      else begin
        expRes = expQ.pop_front();
        if ({bus.res_data, bus.res_zero, bus.res_dz, bus.res_ill} !== expRes)
          $display("[TB] FAIL op%0h_result: got %h required %h", i, {bus.res_data, bus.res_zero, bus.res_dz, bus.res_ill}, expRes);
        else passes++;
      end
      takeResult();
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] expRes;
    bit          pendingPush;
    int          collected;
    int          lastCyc;
    bus.res_ready = 1'b0;
    sendCmd(4'hF, 4'hF, 4'h3, {8'hE1, 3'b000});
    sendCmd(4'h3, 4'h5, 4'h1, {8'hFE, 3'b000});
    sendCmd(4'h6, 4'h3, 4'hC, {8'h05, 3'b000});
    checks++;
    if ({bus.cmd_ready, bus.res_valid} !== 2'b01) $display("[TB] FAIL bp_full: got ready/valid %b required 01", {bus.cmd_ready, bus.res_valid});
    else passes++;
    bus.cmd_a     = 4'h0;
    bus.cmd_b     = 4'h0;
    bus.cmd_op    = 4'h9;
    bus.cmd_valid = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.cmd_ready, bus.res_valid, bus.res_data} !== {2'b01, 8'hE1})
      $display("[TB] FAIL bp_stall: got ready=%b valid=%b data=%h required 0 1 e1", bus.cmd_ready, bus.res_valid, bus.res_data);
    else passes++;
    bus.res_ready = 1'b1;
    collected = 0;
    lastCyc   = 0;
    for (int cyc = 0; cyc < 40 && collected < 4; cyc++) begin
      if (cyc == 1) begin
        checks++;
        if (bus.cmd_ready !== 1'b1) $display("[TB] FAIL bp_ready_rise: got %b required 1", bus.cmd_ready);
        else passes++;
      end
      pendingPush = bus.cmd_valid && bus.cmd_ready;
      if (bus.res_valid) begin
        checks++;
        if (expQ.size() == 0) $display("[TB] FAIL bp_result%0d: got extra result %h required none", collected, bus.res_data);
        else begin
          expRes = expQ.pop_front();
          if ({bus.res_data, bus.res_zero, bus.res_dz, bus.res_ill} !== expRes)
            $display("[TB] FAIL bp_result%0d: got %h required %h", collected, {bus.res_data, bus.res_zero, bus.res_dz, bus.res_ill}, expRes);
          else passes++;
        end
        if (collected > 0) begin
          checks++;
          if (cyc - lastCyc !== 2) $display("[TB] FAIL bp_spacing%0d: got %0d cycles required 2", collected, cyc - lastCyc);
          else passes++;
        end
        lastCyc = cyc;
        collected++;
      end
      if (pendingPush) expQ.push_back({8'hFF, 3'b000});
      @(posedge clk);
      @(negedge clk);
      if (pendingPush) bus.cmd_valid = 1'b0;
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({collected, expQ.size(), bus.res_valid, busy} !== {32'd4, 32'd0, 2'b00})
      $display("[TB] FAIL bp_drain: got results=%0d queued=%0d valid=%b busy=%b required 4 0 0 0",
               collected, expQ.size(), bus.res_valid, busy);
    else passes++;
    bus.res_ready = 1'b0;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [10:0] expRes;
    bit          seen;
    int          cyc;
    bus.res_ready = 1'b0;
    sendCmd(4'h1, 4'h1, 4'h0, {8'h02, 3'b000});
    sendCmd(4'h2, 4'h2, 4'h0, {8'h04, 3'b000});
    sendCmd(4'h3, 4'h3, 4'h0, {8'h06, 3'b000});
    checks++;
    if ({bus.cmd_ready, bus.res_valid} !== 2'b01) $display("[TB] FAIL rst_mid_full: got ready/valid %b required 01", {bus.cmd_ready, bus.res_valid});
    else passes++;
    rstN = 1'b0;
    #1;
    checks++;
    if ({bus.cmd_ready, bus.res_valid, bus.res_data, bus.res_zero, bus.res_dz, bus.res_ill,
         busy, opCount, aluA, aluB, aluOp} !== 30'h0)
      $display("[TB] FAIL rst_mid_outputs: got ready=%b valid=%b data=%h busy=%b cnt=%h required all 0",
               bus.cmd_ready, bus.res_valid, bus.res_data, busy, opCount);
    else passes++;
    expQ.delete();
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, bus.res_valid, bus.cmd_ready} !== 3'b001) $display("[TB] FAIL rst_mid_empty: got busy/valid/ready %b required 001", {busy, bus.res_valid, bus.cmd_ready});
    else passes++;
    sendCmd(4'h2, 4'h3, 4'h0, {8'h05, 3'b000});
    waitResult(seen, cyc);
    checks++;
    if (!seen || expQ.size() == 0) $display("[TB] FAIL rst_mid_result: got no result required one");
    else begin
      expRes = expQ.pop_front();
      if ({bus.res_data, bus.res_zero, bus.res_dz, bus.res_ill} !== expRes)
        $display("[TB] FAIL rst_mid_result: got %h required %h", {bus.res_data, bus.res_zero, bus.res_dz, bus.res_ill}, expRes);
      else passes++;
    end
    takeResult();
    checks++;
    if (opCount !== 4'd1) $display("[TB] FAIL rst_mid_count: got %0d required 1", opCount);
    else passes++;
  endtask

  task automatic test_wrap();
    logic [10:0] expRes;
    bit          seen;
    int          cyc;
    doReset();
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        checks++;
        if (opCount !== 4'hF) $display("[TB] FAIL wrap_full: got %h required f", opCount);
        else passes++;
        sendCmd(4'h0, 4'h0, 4'h0, {8'h00, 3'b100});
      end else begin
        sendCmd(4'(i), 4'h1, 4'h0, {8'(i + 1), 3'b000});
      end
      waitResult(seen, cyc);
      checks++;
      if (!seen || expQ.size() == 0) $display("[TB] FAIL wrap_result%0d: got no result required one", i);
      else begin
        expRes = expQ.pop_front();
        if ({bus.res_data, bus.res_zero, bus.res_dz, bus.res_ill} !== expRes)
          $display("[TB] FAIL wrap_result%0d: got %h required %h", i, {bus.res_data, bus.res_zero, bus.res_dz, bus.res_ill}, expRes);
        else passes++;
      end
      takeResult();
    end
    checks++;
    if (opCount !== 4'h0) $display("[TB] FAIL wrap_zero: got %h required 0", opCount);
    else passes++;
  endtask

  initial begin
    rstN          = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = 4'h0;
    bus.cmd_b     = 4'h0;
    bus.cmd_op    = 4'h0;
    bus.res_ready = 1'b0;
    repeat (3) @(negedge clk);
    $display("[TB] starting alu_issue_stage tests");
    test_reset();
    test_latency();
    test_div();
    test_illegal();
    test_opcodes();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
